// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
package exec_pkg;

  localparam int EXEC_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_stage_mul_iter.sv
// Shift-add iterative multiplier. Operands are captured on start, then one
// multiplier bit is retired per cycle. done is asserted during the final
// iteration and product already includes that last partial product, so the
// consumer can load it on the same edge that retires the iteration.
module mul_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = EXEC_WIDTH
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier;

  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  // Operand capture on start, then one add/shift step per cycle until done.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply, with a registered
// result/flags/writeback-select presented through a valid/ready output.
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = EXEC_WIDTH
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_sel,
  output logic             zero,
  output logic             carry
);

  state_e state_q, state_d;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               alu_load;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               dst_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     sum;

  // A new op is only taken when idle and the output slot is free or draining.
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign alu_load  = accept && !is_mul;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ALU result and carry/borrow flag.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op_e'(op))
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = a - b;
        alu_c   = (a < b);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = a << 1;
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = a >> 1;
        alu_c   = a[0];
      end
      default: ;
    endcase
  end

  // Next-state: leave IDLE on a multiply, return once it retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Destination select held for the duration of a multiply.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)         dst_q <= 1'b0;
    else if (mul_start) dst_q <= dst;
  end

  // Output register: load on ALU accept or multiply completion, else drain.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      wb_sel    <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else if (alu_load) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      wb_sel    <= dst;
      zero      <= (alu_res == '0);
      carry     <= alu_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product[WIDTH-1:0];
      wb_sel    <= dst_q;
      zero      <= (mul_product[WIDTH-1:0] == '0);
      carry     <= |mul_product[2*WIDTH-1:WIDTH];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed vectors, immediate assertions.
module tb_exec_stage;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       dst;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       wb_sel;
  logic       zero;
  logic       carry;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  exec_stage #(.WIDTH(8)) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .dst       (dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .wb_sel    (wb_sel),
    .zero      (zero),
    .carry     (carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic d);
    in_valid = v; op = o; a = x; b = y; dst = d;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] r,
                         input logic w, input logic z, input logic c);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".result"},    {24'd0, result},    {24'd0, r});
    chk({tag, ".wb_sel"},    {31'd0, wb_sel},    {31'd0, w});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, z});
    chk({tag, ".carry"},     {31'd0, carry},     {31'd0, c});
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    #2;
    chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset.out_valid", {31'd0, out_valid}, 32'd0);

    // ADD with carry out and zero result
    drive(1'b1, 3'b000, 8'hFF, 8'h01, 1'b0);
    step();
    chk_out("add_ff_01", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

    // SUB with borrow, back-to-back
    drive(1'b1, 3'b001, 8'h03, 8'h05, 1'b1);
    step();
    chk_out("sub_borrow", 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1);

    // SHR logical with carry = a[0]
    drive(1'b1, 3'b110, 8'h81, 8'h00, 1'b0);
    step();
    chk_out("shr_81", 1'b1, 8'h40, 1'b0, 1'b0, 1'b1);

    // SUB without borrow, AND, SHL, XOR, ADD without carry
    drive(1'b1, 3'b001, 8'h05, 8'h03, 1'b0);
    step();
    chk_out("sub_noborrow", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 8'hF0, 8'h3C, 1'b1);
    step();
    chk_out("and", 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b101, 8'h81, 8'h00, 1'b0);
    step();
    chk_out("shl_81", 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'b100, 8'h5A, 8'h5A, 1'b0);
    step();
    chk_out("xor_zero", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'b000, 8'h10, 8'h20, 1'b1);
    step();
    chk_out("add_nocarry", 1'b1, 8'h30, 1'b1, 1'b0, 1'b0);

    // MUL 0x0C * 0x0B = 0x84, latency 8
    drive(1'b1, 3'b111, 8'h0C, 8'h0B, 1'b1);
    chk("mul1.pre_ready", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 3'b000, 8'hEE, 8'hEE, 1'b0);
    for (int k = 1; k < 8; k++) begin
      chk("mul1.busy_ready", {31'd0, in_ready}, 32'd0);
      chk("mul1.busy_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    chk("mul1.edge7_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk_out("mul1", 1'b1, 8'h84, 1'b1, 1'b0, 1'b0);
    chk("mul1.done_ready", {31'd0, in_ready}, 32'd1);

    // MUL 0x10 * 0x10 = 0x100: low byte zero, high nonzero
    drive(1'b1, 3'b111, 8'h10, 8'h10, 1'b0);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    for (int k = 1; k < 8; k++) step();
    chk("mul2.edge7_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk_out("mul2", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

    // Backpressure: OR result held while out_ready low
    drive(1'b1, 3'b011, 8'hA0, 8'h05, 1'b0);
    step();
    chk_out("or", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 8'hFF, 8'h0F, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp.hold", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_out("bp.drain_accept", 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    step();
    chk("bp.consumed", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply
    drive(1'b1, 3'b111, 8'h03, 8'h05, 1'b1);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    chk_out("midmul_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midmul_reset.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("after_reset.no_valid", {31'd0, out_valid}, 32'd0);
    end
    drive(1'b1, 3'b000, 8'h02, 8'h03, 1'b0);
    step();
    chk_out("after_reset.add", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
